// File: rtl/mux_stim_gen.sv
// Reproducible LFSR stimulus source for the 2:1 mux: emits num_vec vectors on in1/in2/sel, one every PERIOD cycles.
// Define MUX_STIM_EXPECT_EN to add exp_out, the expected mux output for each vector.
module mux_stim_gen #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          PERIOD = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] num_vec,
  output logic        in1,
  output logic        in2,
  output logic        sel,
  output logic        vec_valid,
  output logic        busy,
  output logic        done,
`ifdef MUX_STIM_EXPECT_EN
  output logic        exp_out,
`endif
  output logic [1:0]  state_dbg
);

  // Handshake: start is level-sampled only in IDLE; busy is high from the
  // accept edge through the final vec_valid cycle; done is a one-cycle pulse
  // the cycle after the final vec_valid; vec_valid marks each new vector.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMAX = 16'(PERIOD - 1);

  state_t      state, state_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic [15:0] timer;
  logic [15:0] vec_cnt;
  logic [15:0] num_lat;
  logic        tick;
  logic        last;

  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign tick      = (timer == TMAX);
  // 17-bit compare so num_vec=FFFF terminates without vec_cnt wrapping first
  assign last      = (({1'b0, vec_cnt} + 17'd1) == {1'b0, num_lat});
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (num_vec != 16'd0) ? RUN : DONE;
      RUN:  if (tick && last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      timer     <= 16'd0;
      vec_cnt   <= 16'd0;
      num_lat   <= 16'd0;
      in1       <= 1'b0;
      in2       <= 1'b0;
      sel       <= 1'b0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MUX_STIM_EXPECT_EN
      exp_out   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      vec_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_next == RUN) || (state == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            num_lat <= num_vec;
            timer   <= 16'd0;
            vec_cnt <= 16'd0;
          end
        end
        RUN: begin
          if (tick) begin
            timer     <= 16'd0;
            vec_cnt   <= vec_cnt + 16'd1;
            lfsr      <= lfsr_step;
            in1       <= lfsr_step[0];
            in2       <= lfsr_step[1];
            sel       <= lfsr_step[2];
            vec_valid <= 1'b1;
`ifdef MUX_STIM_EXPECT_EN
            exp_out   <= lfsr_step[2] ? lfsr_step[1] : lfsr_step[0];
`endif
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
